// File: rtl/alu_pipe_flags_if.sv
`default_nettype none
// ============================================================================
//  Module   : alu_pipe_flags_if
//  Brief    : Handshake/operand/result bundle for the pipelined flag ALU.
//             master = producer/consumer side, slave = ALU side.
//  Revision : 1.0 - initial release
// ============================================================================
interface alu_pipe_flags_if #(
  parameter int WIDTH = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [3:0]       opcode;
  logic [WIDTH-1:0] alu_in1;
  logic [WIDTH-1:0] alu_in2;
  logic             flush;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] alu_out;
  logic             error;
  logic [2:0]       flags;

  modport master (
    output in_valid, opcode, alu_in1, alu_in2, flush, out_ready,
    input  in_ready, out_valid, alu_out, error, flags
  );

  modport slave (
    input  in_valid, opcode, alu_in1, alu_in2, flush, out_ready,
    output in_ready, out_valid, alu_out, error, flags
  );
endinterface
`default_nettype wire

// File: rtl/alu_pipe_flags.sv
`default_nettype none
// ============================================================================
//  Module   : alu_pipe_flags
//  Brief    : Single-stage pipelined ALU with valid/ready handshake, registered
//             result/error and an architectural {Z,V,N} flag register that
//             updates on accept using per-opcode masks.
//             Optional macro ALU_SAT_EN: ADD/SUB saturate on signed overflow
//             instead of wrapping.
//  Revision : 1.0 - initial release
// ============================================================================
module alu_pipe_flags #(
  parameter int WIDTH = 16,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  wire logic         clk,
  input  wire logic         rst_n,
  alu_pipe_flags_if.slave   bus
);

  localparam logic [3:0] OP_ADD    = 4'd0;
  localparam logic [3:0] OP_SUB    = 4'd1;
  localparam logic [3:0] OP_XOR    = 4'd2;
  localparam logic [3:0] OP_RED    = 4'd3;
  localparam logic [3:0] OP_SLL    = 4'd4;
  localparam logic [3:0] OP_SRA    = 4'd5;
  localparam logic [3:0] OP_ROR    = 4'd6;
  localparam logic [3:0] OP_PADDSB = 4'd7;

  // Flag bit positions within {Z,V,N}
  localparam logic [2:0] MASK_ALL  = 3'b111;
  localparam logic [2:0] MASK_Z    = 3'b100;
  localparam logic [2:0] MASK_NONE = 3'b000;

  logic [WIDTH-1:0]   a, b;
  logic [SHW-1:0]     sh;
  logic [WIDTH-1:0]   sum, diff, sat_val;
  logic               v_add, v_sub;
  logic [2*WIDTH-1:0] ror_wide;
  logic [WIDTH-1:0]   red_sum;
  logic [WIDTH-1:0]   padd_res;
  logic signed [4:0]  padd_lane;

  logic [WIDTH-1:0]   res_d;
  logic               err_d;
  logic               ov_d;
  logic [2:0]         mask_d;
  logic [2:0]         flags_d;

  logic               out_valid_q;
  logic [WIDTH-1:0]   alu_out_q;
  logic               error_q;
  logic [2:0]         flags_q;

  logic               in_ready;
  logic               accept;

  assign a  = bus.alu_in1;
  assign b  = bus.alu_in2;
  assign sh = b[SHW-1:0];

  // Overflow: operands of like sign (ADD) / unlike sign (SUB) producing a
  // result whose sign differs from A.
  assign sum      = a + b;
  assign diff     = a - b;
  assign v_add    = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1]  != a[WIDTH-1]);
  assign v_sub    = (a[WIDTH-1] != b[WIDTH-1]) && (diff[WIDTH-1] != a[WIDTH-1]);
  // Overflow direction always follows the sign of A for both ADD and SUB.
  assign sat_val  = a[WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
  // Rotating the doubled word makes a zero shift return A unchanged.
  assign ror_wide = {a, a} >> sh;

  // Signed byte-lane reduction over both operands, sign-extended to WIDTH.
  always_comb begin
    red_sum = '0;
    for (int i = 0; i < WIDTH / 8; i++) begin
      red_sum = red_sum + WIDTH'($signed(a[8*i +: 8])) + WIDTH'($signed(b[8*i +: 8]));
    end
  end

  // Nibble-wise signed add, each lane clamped to 0x7 / 0x8.
  always_comb begin
    padd_res  = '0;
    padd_lane = '0;
    for (int i = 0; i < WIDTH / 4; i++) begin
      padd_lane = $signed({a[4*i+3], a[4*i +: 4]}) + $signed({b[4*i+3], b[4*i +: 4]});
      if (padd_lane > 5'sd7) begin
        padd_res[4*i +: 4] = 4'h7;
      end else if (padd_lane < -5'sd8) begin
        padd_res[4*i +: 4] = 4'h8;
      end else begin
        padd_res[4*i +: 4] = padd_lane[3:0];
      end
    end
  end

  // Opcode decode: result, error, overflow and flag-update mask.
  always_comb begin
    res_d  = '0;
    err_d  = 1'b0;
    ov_d   = 1'b0;
    mask_d = MASK_NONE;
    case (bus.opcode)
      OP_ADD: begin
        res_d  = sum;
`ifdef ALU_SAT_EN
        if (v_add) res_d = sat_val;
`endif
        ov_d   = v_add;
        err_d  = v_add;
        mask_d = MASK_ALL;
      end
      OP_SUB: begin
        res_d  = diff;
`ifdef ALU_SAT_EN
        if (v_sub) res_d = sat_val;
`endif
        ov_d   = v_sub;
        err_d  = v_sub;
        mask_d = MASK_ALL;
      end
      OP_XOR: begin
        res_d  = a ^ b;
        mask_d = MASK_Z;
      end
      OP_RED:    res_d = red_sum;
      OP_SLL: begin
        res_d  = a << sh;
        mask_d = MASK_Z;
      end
      OP_SRA: begin
        res_d  = $signed(a) >>> sh;
        mask_d = MASK_Z;
      end
      OP_ROR: begin
        res_d  = ror_wide[WIDTH-1:0];
        mask_d = MASK_Z;
      end
      OP_PADDSB: res_d = padd_res;
      default:   err_d = 1'b1;
    endcase
  end

  // Merge freshly computed flags into the architectural register under mask.
  always_comb begin
    flags_d = (flags_q & ~mask_d) |
              ({(res_d == '0), ov_d, res_d[WIDTH-1]} & mask_d);
  end

  assign in_ready = !out_valid_q || bus.out_ready;
  assign accept   = bus.in_valid && in_ready && !bus.flush;

  // Result/flag pipeline register; flush beats accept, stall holds output.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      alu_out_q   <= '0;
      error_q     <= 1'b0;
      flags_q     <= 3'b000;
    end else if (bus.flush) begin
      out_valid_q <= 1'b0;
    end else if (accept) begin
      out_valid_q <= 1'b1;
      alu_out_q   <= res_d;
      error_q     <= err_d;
      flags_q     <= flags_d;
    end else if (bus.out_ready) begin
      out_valid_q <= 1'b0;
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid_q;
  assign bus.alu_out   = alu_out_q;
  assign bus.error     = error_q;
  assign bus.flags     = flags_q;

endmodule
`default_nettype wire

// File: doc/alu_pipe_flags.md
Name: alu_pipe_flags

Overview:
- Parametrised, single-stage pipelined ALU for the next-generation datapath.
- Generalises the 16-bit combinational ALU in width. Adds a valid/ready handshake, a registered result, and an architectural Z/V/N flag register with per-opcode update masks.
- Sits between register-read and writeback. Branch logic reads `flags` directly.

Parameters:
- WIDTH, 16: operand/result width. Must be a multiple of 8 and at least 8.
- SHW, $clog2(WIDTH): shift-amount width, taken from In2[SHW-1:0].

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  operation presented
- in_ready  out  1  block can accept an operation this cycle
- opcode  in  4  operation select
- alu_in1  in  WIDTH  operand A
- alu_in2  in  WIDTH  operand B / shift amount
- flush  in  1  synchronous drop of pending result
- out_valid  out  1  alu_out/error valid
- out_ready  in  1  consumer accepts result
- alu_out  out  WIDTH  registered result
- error  out  1  registered overflow or illegal-opcode indication
- flags  out  3  architectural flags {Z,V,N}

Behaviour:
- Reset (rst_n low, asynchronous): out_valid=0, alu_out=0, error=0, flags=3'b000. in_ready=1 once reset deasserts.
- in_ready = !out_valid || out_ready (combinational).
- Accept occurs when in_valid && in_ready. The result is registered on that edge, so latency = 1 cycle. Back-to-back accepts give 1 op/cycle.
- Result is held while out_valid && !out_ready. alu_out, error and out_valid do not change during the stall.
- out_valid clears after a handshake when there is no new accept. Simultaneous accept and handshake: out_valid stays 1 and the new result replaces the old.
- flush=1: out_valid clears next edge and any accept in that cycle is discarded. Flags are not updated by a flushed op. flush takes priority over accept.
- Flags update on the accept edge, not at handshake, using the masks below. Unmasked bits hold.
- Opcodes:
  - 0 ADD: Z, V, N updated. V = signed overflow.
  - 1 SUB (A-B): Z, V, N updated.
  - 2 XOR: Z updated. V, N hold.
  - 3 RED: signed sum of all 8-bit lanes of A and B, sign-extended to WIDTH. No flag update.
  - 4 SLL: Z updated.
  - 5 SRA: Z updated.
  - 6 ROR: Z updated. Shift amount 0 returns A unchanged.
  - 7 PADDSB: independent 4-bit signed lanes, each saturating to 0x7/0x8. No flag update. Never sets error.
  - 8–15 illegal: alu_out=0, error=1, flags hold, out_valid still asserts.
- Flag and error definitions:
  - Z = (result == 0).
  - N = result[WIDTH-1].
  - error = V for ADD/SUB, 0 for other legal ops.
- All arithmetic is WIDTH bits, two's complement. Carry-out is discarded.
- Reset asserted mid-stall drops the pending result and clears flags.

Optional Feature:
- Macro: ALU_SAT_EN.
- Defined: on signed overflow, ADD/SUB results saturate to 0x7FF..F (positive overflow) or 0x800..0 (negative overflow). V=1 and error=1. N reflects the saturated value.
- Undefined: results wrap modulo 2^WIDTH. V and error still flag the overflow. N reflects the wrapped value.

Test Plan (WIDTH=16):
- Reset, then ADD 0x7FFF+0x0001.
  - With ALU_SAT_EN: alu_out=0x7FFF, flags=3'b010, error=1 one cycle after accept.
  - Without ALU_SAT_EN: alu_out=0x8000, flags=3'b011.
- SUB 0x0005-0x0005 -> alu_out=0x0000, flags=3'b100. Next op XOR 0x00FF^0x0F00 -> alu_out=0x0FFF, flags=3'b000 (Z cleared; V, N held).
- Shifts and PADDSB, one per cycle:
  - SRA 0x8000 by 4 -> 0xF800.
  - ROR 0x8001 by 1 -> 0xC000.
  - SLL 0x0001 by 15 -> 0x8000.
  - PADDSB 0x7788+0x1188 -> 0x7788.
  - RED 0x0102,0x0304 -> 0x000A.
  - Flags change only on the SRA/ROR/SLL ops.
- Stall: hold out_ready=0 for 3 cycles with in_valid=1 -> in_ready=0, alu_out stable. Release -> simultaneous handshake+accept, out_valid stays 1, new result appears.
- Illegal opcode 4'hA -> error=1, alu_out=0, flags unchanged, out_valid=1.
- Control edge cases:
  - flush asserted with in_valid=1 -> out_valid=0 next cycle, flags unchanged.
  - rst_n pulsed low mid-stall -> all outputs zero immediately.
